serial_addsub: RTL and testbench

//  Bit-serial add/subtract unit: takes WIDTH-bit operands and processes one bit per clock, LSB first.

---
 rtl/serial_addsub_pkg.sv | 10 +
 rtl/serial_addsub_full_adder.sv | 16 +
 rtl/serial_addsub.sv | 103 ++++++++++
 tb/tb_serial_addsub.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared state encoding for the bit-serial add/subtract unit.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder; the only arithmetic in the serial engine.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);

   logic w_axb;

   assign w_axb = A ^ B;
   assign S     = w_axb ^ Cin;
   assign Cout  = (A & B) | (Cin & w_axb);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single full adder.
// Subtraction runs as a + ~b + 1 with the carry flop preloaded from sub.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | shifting one bit per clock, busy=1
// S_DONE | one-cycle done pulse; start here chains the next op
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic             w_accept;
   logic             w_last;
   logic             w_sum;
   logic             w_cout;

   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

   full_adder u_fa (
      .A    (r_sh_a[0]),
      .B    (r_sh_b[0]),
      .Cin  (r_carry),
      .S    (w_sum),
      .Cout (w_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_sh_a   <= '0;
         r_sh_b   <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_sh_a  <= a;
         r_sh_b  <= sub ? ~b : b;
         r_carry <= sub;
      end else if (r_state == S_RUN) begin
         r_result <= {w_sum, r_result[WIDTH-1:1]};
         r_sh_a   <= {1'b0, r_sh_a[WIDTH-1:1]};
         r_sh_b   <= {1'b0, r_sh_b[WIDTH-1:1]};
         r_carry  <= w_cout;
         // explicit wrap keeps non-power-of-two widths in range
         r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
         if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= r_carry ^ w_cout;
         end
      end
   end

   assign busy   = (r_state == S_RUN);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8) plus an exhaustive WIDTH=4 sweep.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       sub = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       busy, done, cout, ovf;
   logic [7:0] result;

   logic       start4 = 1'b0;
   logic       sub4 = 1'b0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       busy4, done4, cout4, ovf4;
   logic [3:0] result4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
   );

   serial_addsub #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
   );

   // {cout, ovf, result} for a 4-bit op
   function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y, input logic s);
      logic [3:0] yy;
      logic [4:0] t;
      yy = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, yy} + {4'b0, s};
      return {t[4], (x[3] == yy[3]) && (t[3] != x[3]), t[3:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one op and wait for done; lat = edges after the accepting edge.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        output int lat, output int nbusy);
      a = ta; b = tb_v; sub = ts; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0; nbusy = 0;
      while (!done && lat < 20) begin
         if (busy) nbusy++;
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      n_checks++;
      if ({busy, done, cout, ovf, result} !== 12'h0) begin
         n_errors++;
         $display("FAIL reset8 got %h exp 000", {busy, done, cout, ovf, result});
      end
      n_checks++;
      if ({busy4, done4, cout4, ovf4, result4} !== 8'h0) begin
         n_errors++;
         $display("FAIL reset4 got %h exp 00", {busy4, done4, cout4, ovf4, result4});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      int lat, nb;
      do_op(8'h5A, 8'h33, 1'b0, lat, nb);
      n_checks++;
      if ({cout, ovf, result} !== 10'h18D) begin
         n_errors++;
         $display("FAIL add_5a_33 got %h exp 18d", {cout, ovf, result});
      end
      n_checks++;
      if (lat !== 8) begin
         n_errors++;
         $display("FAIL add_latency got %0d exp 8", lat);
      end
      n_checks++;
      if (nb !== 8) begin
         n_errors++;
         $display("FAIL add_busy_cycles got %0d exp 8", nb);
      end
      tick();
      n_checks++;
      if ({busy, done, cout, ovf, result} !== 12'h18D) begin
         n_errors++;
         $display("FAIL add_idle_hold got %h exp 18d", {busy, done, cout, ovf, result});
      end
      do_op(8'hFF, 8'h01, 1'b0, lat, nb);
      n_checks++;
      if ({cout, ovf, result} !== 10'h200 || lat !== 8) begin
         n_errors++;
         $display("FAIL add_ff_01 got %h lat %0d exp 200 lat 8", {cout, ovf, result}, lat);
      end
      tick();
   endtask

   task automatic test_sub();
      int lat, nb;
      do_op(8'h10, 8'h20, 1'b1, lat, nb);
      n_checks++;
      if ({cout, ovf, result} !== 10'h0F0 || lat !== 8) begin
         n_errors++;
         $display("FAIL sub_10_20 got %h lat %0d exp 0f0 lat 8", {cout, ovf, result}, lat);
      end
      do_op(8'h80, 8'h01, 1'b1, lat, nb);
      n_checks++;
      if ({cout, ovf, result} !== 10'h37F || lat !== 8) begin
         n_errors++;
         $display("FAIL sub_80_01 got %h lat %0d exp 37f lat 8", {cout, ovf, result}, lat);
      end
      tick();
   endtask

   task automatic test_ignore_start();
      int ndone, first;
      logic [9:0] got;
      got = '0;
      a = 8'h5A; b = 8'h33; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; a = '0; b = '0; sub = 1'b0;
      ndone = 0; first = 0;
      for (int i = 4; i <= 20; i++) begin
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               first = i - 1;
               got = {cout, ovf, result};
            end
         end
         tick();
      end
      n_checks++;
      if (ndone !== 1) begin
         n_errors++;
         $display("FAIL ignore_done_count got %0d exp 1", ndone);
      end
      n_checks++;
      if (got !== 10'h18D || first !== 8) begin
         n_errors++;
         $display("FAIL ignore_result got %h at %0d exp 18d at 8", got, first);
      end
   endtask

   task automatic test_reset_mid();
      int lat, nb, ndone;
      a = 8'h5A; b = 8'h33; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({busy, done, cout, ovf, result} !== 12'h0) begin
         n_errors++;
         $display("FAIL midreset_outputs got %h exp 000", {busy, done, cout, ovf, result});
      end
      rst_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         tick();
         if (done || busy) ndone++;
      end
      n_checks++;
      if (ndone !== 0) begin
         n_errors++;
         $display("FAIL midreset_no_done got %0d exp 0", ndone);
      end
      do_op(8'h03, 8'h05, 1'b1, lat, nb);
      n_checks++;
      if ({cout, ovf, result} !== 10'h0FE || lat !== 8) begin
         n_errors++;
         $display("FAIL midreset_recover got %h lat %0d exp 0fe lat 8", {cout, ovf, result}, lat);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc, d1, d2;
      logic [9:0] r1, r2;
      logic acc_ok;
      d1 = -1; d2 = -1; r1 = '0; r2 = '0; acc_ok = 1'b0;
      a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
      tick();
      a = 8'h03; b = 8'h01; sub = 1'b1;
      cyc = 0;
      while (d2 < 0 && cyc < 40) begin
         tick();
         cyc++;
         if (d1 >= 0 && cyc == d1 + 1) begin
            start = 1'b0;
            acc_ok = busy && !done;
         end
         if (done) begin
            if (d1 < 0) begin
               d1 = cyc; r1 = {cout, ovf, result};
            end else begin
               d2 = cyc; r2 = {cout, ovf, result};
            end
         end
      end
      start = 1'b0;
      n_checks++;
      if (d1 !== 8 || d2 - d1 !== 9) begin
         n_errors++;
         $display("FAIL b2b_spacing got d1 %0d d2 %0d exp 8 17", d1, d2);
      end
      n_checks++;
      if (r1 !== 10'h002 || r2 !== 10'h202) begin
         n_errors++;
         $display("FAIL b2b_results got %h %h exp 002 202", r1, r2);
      end
      n_checks++;
      if (acc_ok !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_accept_in_done got %b exp 1", acc_ok);
      end
      tick();
   endtask

   task automatic test_sweep4();
      int bad, n;
      logic [5:0] exp_v;
      bad = 0;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            for (int s = 0; s < 2; s++) begin
               a4 = 4'(x); b4 = 4'(y); sub4 = s[0]; start4 = 1'b1;
               tick();
               start4 = 1'b0;
               n = 0;
               while (!done4 && n < 10) begin
                  tick();
                  n++;
               end
               exp_v = model4(4'(x), 4'(y), s[0]);
               n_checks++;
               if ({cout4, ovf4, result4} !== exp_v || n !== 4) begin
                  n_errors++;
                  bad++;
                  if (bad <= 5)
                     $display("FAIL sweep4 a=%h b=%h sub=%0d got %h lat %0d exp %h lat 4",
                              x, y, s, {cout4, ovf4, result4}, n, exp_v);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_sweep4();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
